seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV_CYCLES, default 100000, SHALL set clk cycles per digit slot; legal range 2..2^24.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ones  input  4  BCD digit 0 (least significant), from bcd11.
REQ-005 tens  input  4  BCD digit 1.
REQ-006 hundreds  input  4  BCD digit 2.
REQ-007 thousands  input  4  BCD digit 3.
REQ-008 in_valid  input  1  high for one or more cycles; the digits SHALL be captured into the shadow register on each cycle it is high.
REQ-009 an  output  4  active-low anode enables; an[0]=ones ... an[3]=thousands.
REQ-010 seg  output  7  active-low cathodes, order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  decimal point, SHALL be constant 1 (off).
REQ-012 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 Prescaler SHALL count 0..DIV_CYCLES-1 and wrap; tick SHALL assert on the cycle count==DIV_CYCLES-1.
REQ-014 Digit index (2 bits) SHALL advance on tick: 0->1->2->3->0.
REQ-015 Frame wrap = tick with index==3; on that edge the display register SHALL load the shadow register, and frame_done SHALL be 1 for the following cycle only.
REQ-016 If in_valid and frame wrap coincide, display SHALL load the pre-edge shadow value; the new digits SHALL appear from the next frame.
REQ-017 an and seg SHALL be registered: one cycle latency from index/display register to pins.
REQ-018 an SHALL drive exactly one bit low, selected by index, unless that digit is blanked (REQ-025), in which case an=4'b1111.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Codes 10..15 SHALL display a dash, seg=0111111.
REQ-021 in_valid changes SHALL never alter the digit currently lit mid-frame (no tearing).

Reset
REQ-022 On reset: prescaler=0, index=0, shadow=0, display=0, an=4'b1111, seg=7'b1111111, frame_done=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; first cycle after release SHALL show an=4'b1111; second cycle an=4'b1110, seg=1000000.
REQ-024 in_valid during reset SHALL be ignored.

Configuration
REQ-025 Macro LZ_BLANK_EN defined: leading-zero blanking; thousands blanked if 0; hundreds blanked if thousands and hundreds are 0; tens blanked if thousands, hundreds, tens all 0; ones never blanked; blanked slot keeps its time slot.
REQ-026 Macro LZ_BLANK_EN undefined: all four digits SHALL always be lit in turn; no blanking logic synthesised.

Structure
REQ-027 Package seg_pkg SHALL hold NUM_DIGITS=4, the ten digit segment constants, SEG_DASH, SEG_OFF, and the digit-index typedef.
REQ-028 Sub-module bcd_to_seg (combinational, 4-bit in, 7-bit out per REQ-019/020) SHALL be instantiated once on the selected digit.

Verification (DIV_CYCLES=4)
REQ-029 Reset, then in_valid with digits 1,2,3,4 (thousands..ones) -> after first wrap, an cycles 1110/1101/1011/0111 with seg 0011001/0110000/0100100/1111001, each held 4 cycles.
REQ-030 Count cycles between frame_done pulses -> exactly 16; pulse width 1.
REQ-031 LZ_BLANK_EN defined, digits 0,0,4,0 -> ones slot seg=1000000, tens slot seg=0011001, hundreds and thousands slots an=1111.
REQ-032 Digits 0,0,0,0 with LZ_BLANK_EN -> only ones lit, seg=1000000; without macro all four show 1000000.
REQ-033 in_valid (digits 9,9,9,9) on exact wrap cycle -> old value shown for one full frame, 0010000 on all digits in the frame after.
REQ-034 Ones input 4'hC -> ones slot seg=0111111; reset asserted mid-frame -> an=1111, seg=1111111 next cycle, frame_done=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit active-low 7-segment display.
// Define LZ_BLANK_EN to blank leading zeros on the upper three digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            ones,
    input  logic [3:0]            tens,
    input  logic [3:0]            hundreds,
    input  logic [3:0]            thousands,
    input  logic                  in_valid,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned      CNT_W    = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0]      cnt_q;
    digit_idx_t            idx_q;
    logic [15:0]           shadow_q;
    logic [15:0]           disp_q;
    logic                  tick;
    logic                  wrap;
    logic [3:0]            sel_bcd;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;

    assign tick = (cnt_q == CNT_LAST);
    assign wrap = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    assign dp   = 1'b1;

    always_comb begin
        sel_bcd = disp_q[3:0];
        case (idx_q)
            2'd0:    sel_bcd = disp_q[3:0];
            2'd1:    sel_bcd = disp_q[7:4];
            2'd2:    sel_bcd = disp_q[11:8];
            default: sel_bcd = disp_q[15:12];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (sel_bcd),
        .seg (dec_seg)
    );

`ifdef LZ_BLANK_EN
    logic lead_blank;

    // A slot blanks only when it and every more significant digit are zero.
    always_comb begin
        lead_blank = 1'b0;
        case (idx_q)
            2'd3:    lead_blank = (disp_q[15:12] == 4'd0);
            2'd2:    lead_blank = (disp_q[15:8] == 8'd0);
            2'd1:    lead_blank = (disp_q[15:4] == 12'd0);
            default: lead_blank = 1'b0;
        endcase
    end
`endif

    always_comb begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = dec_seg;
`ifdef LZ_BLANK_EN
        if (lead_blank) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end
`endif
    end

    // Display only reloads at frame wrap, so a lit digit never changes mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                idx_q <= idx_q + 1'b1;
            end
            if (in_valid) begin
                shadow_q <= {thousands, hundreds, tens, ones};
            end
            if (wrap) begin
                disp_q <= shadow_q;
            end
            frame_done <= wrap;
            an         <= an_d;
            seg        <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux with DIV_CYCLES = 4.
// Expectations adapt to LZ_BLANK_EN when the bench is built with it.
module tb_seg_scan_mux;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SD   = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    // Anode patterns packed {slot3, slot2, slot1, slot0}.
    localparam logic [15:0] AN_ALL = 16'b0111_1011_1101_1110;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ones, tens, hundreds, thousands;
    logic       in_valid;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_mux #(.DIV_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .in_valid   (in_valid),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_wrap(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = frame_done;
        end
        chk({tag, "_wrap_seen"}, {15'd0, seen}, 16'd1);
    endtask

    // Starts just after a wrap edge; walks the 16 cycles of the following frame.
    task automatic check_frame(input string name, input logic [27:0] segs,
                               input logic [15:0] ans, input logic inj,
                               input int inj_step, input logic [15:0] inj_dig);
        for (int st = 0; st < 16; st++) begin
            tick();
            in_valid = 1'b0;
            chk($sformatf("%s_an_s%0d_c%0d", name, st / 4, st % 4), {12'd0, an},
                {12'd0, ans[(st / 4) * 4 +: 4]});
            chk($sformatf("%s_seg_s%0d_c%0d", name, st / 4, st % 4), {9'd0, seg},
                {9'd0, segs[(st / 4) * 7 +: 7]});
            chk($sformatf("%s_fd_%0d", name, st), {15'd0, frame_done},
                {15'd0, (st == 15)});
            if (inj && st == inj_step) begin
                in_valid = 1'b1;
                {thousands, hundreds, tens, ones} = inj_dig;
            end
        end
    endtask

    logic [27:0] segs_zero, segs_1234, segs_9999, segs_0040, segs_567c;
    logic [15:0] ans_zero, ans_0040;

    initial begin
        segs_1234 = {S1, S2, S3, S4};
        segs_9999 = {S9, S9, S9, S9};
        segs_567c = {S5, S6, S7, SD};
`ifdef LZ_BLANK_EN
        segs_zero = {SOFF, SOFF, SOFF, S0};
        ans_zero  = 16'b1111_1111_1111_1110;
        segs_0040 = {SOFF, SOFF, S4, S0};
        ans_0040  = 16'b1111_1111_1101_1110;
`else
        segs_zero = {S0, S0, S0, S0};
        ans_zero  = AN_ALL;
        segs_0040 = {S0, S0, S4, S0};
        ans_0040  = AN_ALL;
`endif

        // Reset with in_valid asserted: the digits must be ignored.
        reset = 1'b1;
        in_valid = 1'b1;
        {thousands, hundreds, tens, ones} = 16'h8888;
        repeat (3) tick();
        chk("rst_an", {12'd0, an}, 16'h000F);
        chk("rst_seg", {9'd0, seg}, {9'd0, SOFF});
        chk("rst_fd", {15'd0, frame_done}, 16'd0);
        chk("rst_dp", {15'd0, dp}, 16'd1);

        reset = 1'b0;
        in_valid = 1'b0;
        {thousands, hundreds, tens, ones} = 16'h0000;
        chk("rel_first_an", {12'd0, an}, 16'h000F);
        tick();
        chk("rel_second_an", {12'd0, an}, 16'h000E);
        chk("rel_second_seg", {9'd0, seg}, {9'd0, S0});

        wait_wrap("boot");
        check_frame("zero", segs_zero, ans_zero, 1'b1, 5, 16'h1234);
        check_frame("d1234", segs_1234, AN_ALL, 1'b1, 14, 16'h9999);
        check_frame("d1234_hold", segs_1234, AN_ALL, 1'b0, 0, 16'h0000);
        check_frame("d9999", segs_9999, AN_ALL, 1'b1, 3, 16'h0040);
        check_frame("d0040", segs_0040, ans_0040, 1'b1, 2, 16'h567C);
        check_frame("d567c", segs_567c, AN_ALL, 1'b0, 0, 16'h0000);

        // Abandon a frame partway through with reset; in_valid during reset is dropped.
        repeat (5) tick();
        reset = 1'b1;
        in_valid = 1'b1;
        {thousands, hundreds, tens, ones} = 16'h8888;
        tick();
        chk("mid_rst_an", {12'd0, an}, 16'h000F);
        chk("mid_rst_seg", {9'd0, seg}, {9'd0, SOFF});
        chk("mid_rst_fd", {15'd0, frame_done}, 16'd0);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mid_rel_first_an", {12'd0, an}, 16'h000F);
        tick();
        chk("mid_rel_second_an", {12'd0, an}, 16'h000E);
        chk("mid_rel_second_seg", {9'd0, seg}, {9'd0, S0});
        chk("mid_rel_second_fd", {15'd0, frame_done}, 16'd0);
        wait_wrap("post_rst");
        check_frame("post_rst_zero", segs_zero, ans_zero, 1'b0, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
